seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle integer divider producing one quotient bit per clock using a restoring shift/subtract datapath. It has a start/busy/done handshake, signed or unsigned mode selected per operation, and divide-by-zero and overflow flags. It is the general-width successor of the team's fixed 8-bit shift/subtract divider, for any datapath needing an area-cheap divide.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `CW`, `$clog2(WIDTH+1)`: iteration counter width; derived, not overridden.

- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `signed_mode` input 1: 1 = two's-complement operands; 0 = unsigned. Latched with `start`.
- `dividend` input WIDTH: latched when `start` is accepted.
- `divisor` input WIDTH: latched when `start` is accepted.
- `busy` output 1: high from the accept edge until the result edge.
- `done` output 1: single-cycle pulse when results update.
- `quotient` output WIDTH: result; holds until the next completion.
- `remainder` output WIDTH: result; holds until the next completion.
- `div_by_zero` output 1: set with `done` when divisor was 0; holds with results.
- `overflow` output 1: set with `done` for signed −2^(WIDTH−1) / −1; holds with results.

## Operation
- States: IDLE, RUN, FINISH.
- **IDLE**
  - `start`=1 latches the operands and the mode.
  - In signed mode, stores operand magnitudes and the sign flags `qneg` = sign(dividend) XOR sign(divisor) and `rneg` = sign(dividend).
  - Divisor = 0: go to FINISH directly.
  - Otherwise: clear the partial remainder (WIDTH+1 bits), load the dividend magnitude into the quotient shift register, counter = WIDTH, go to RUN.
- **RUN**, once per cycle:
  - Shift {partial remainder, quotient register} left 1.
  - Trial = partial remainder − divisor magnitude.
  - If trial ≥ 0, keep the trial and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - Decrement the counter. When the counter reaches 1 on this edge, go to FINISH.
- **FINISH**, one cycle:
  - Write `quotient`/`remainder`; negate the quotient if `qneg`, negate the remainder if `rneg`.
  - Pulse `done`, drop `busy`, return to IDLE.
- Divide by zero: `quotient` = all ones, `remainder` = dividend unmodified, `div_by_zero`=1. Applies in both modes.
- Signed results truncate toward zero; the remainder takes the sign of the dividend.
- Signed −2^(WIDTH−1)/−1: magnitude arithmetic wraps, giving `quotient` = 0x80…0, `remainder` = 0, `overflow`=1.
- `start` while busy: ignored, with no effect on the current operation.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `overflow`=0, internal registers cleared.
- `rst` mid-operation aborts the operation with no `done`, and every output takes its reset value.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.
- Accept edge E0:
  - `busy`=1 visible after E0.
  - Normal operation: RUN at edges E1..E_WIDTH, FINISH at edge E_WIDTH+1. Results, flags and `done`=1 become visible after E_WIDTH+1, with `busy`=0 in the same cycle.
  - Latency: WIDTH+1 clock edges from the accept edge.
- Divide by zero: FINISH at E1, so results are visible after E1 (latency 1).
- `done` is high exactly one cycle.
- The FSM is in IDLE during the `done` cycle, so a `start` in that cycle is accepted. This gives back-to-back throughput of one result per WIDTH+2 cycles.
- Flags clear only at the next completion or at reset.

## Test plan
- Unsigned, WIDTH=8, 100/7: busy for 9 cycles, then `done` pulse, `quotient`=14, `remainder`=2, both flags 0.
- Signed, WIDTH=8, −7/2 (0xF9/0x02): `quotient`=0xFD (−3), `remainder`=0xFF (−1). Also 7/−2: `quotient`=0xFD, `remainder`=0x01.
- Divide by zero, 0x55/0: `done` one edge after accept, `quotient`=0xFF, `remainder`=0x55, `div_by_zero`=1. The next valid divide clears the flag.
- Signed overflow, 0x80/0xFF: `quotient`=0x80, `remainder`=0x00, `overflow`=1.
- Reset and handshake:
  - Assert `rst` for one cycle at RUN iteration 4: `busy`=0 and all outputs 0 next cycle, and no `done` pulse.
  - A `start` pulsed during busy is ignored.
  - A `start` in the `done` cycle is accepted, and its result appears WIDTH+1 edges later.
- WIDTH=16, unsigned 65535/255: `quotient`=257, `remainder`=0, `done` 17 edges after accept. Randomised sweep of operands and modes checked against a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, signed or
// unsigned per operation, with divide-by-zero and signed-overflow flags.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH:0]   rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dsr_p0;
  logic [WIDTH-1:0] dvd_p0;
  logic [CW-1:0]    cnt;
  logic             qneg_p0;
  logic             rneg_p0;
  logic             dz_p0;
  logic             ovf_p0;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             dvd_neg;
  logic             dsr_neg;
  logic             ovf_case;

  // Magnitude of a two's-complement operand; the most negative value wraps to
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    dvd_neg  = signed_mode & dividend[WIDTH-1];
    dsr_neg  = signed_mode & divisor[WIDTH-1];
    ovf_case = signed_mode && (dividend == MIN_NEG) && (&divisor);
    rem_sh   = (rem_p0 << 1) | {{WIDTH{1'b0}}, quo_p0[WIDTH-1]};
    trial    = rem_sh - {1'b0, dsr_p0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_p0      <= '0;
      quo_p0      <= '0;
      dsr_p0      <= '0;
      dvd_p0      <= '0;
      cnt         <= '0;
      qneg_p0     <= 1'b0;
      rneg_p0     <= 1'b0;
      dz_p0       <= 1'b0;
      ovf_p0      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Accept: latch raw dividend (for divide-by-zero), magnitudes and signs
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            dvd_p0  <= dividend;
            quo_p0  <= magnitude($signed(dividend), dvd_neg);
            dsr_p0  <= magnitude($signed(divisor), dsr_neg);
            rem_p0  <= '0;
            cnt     <= CW'(WIDTH);
            qneg_p0 <= dvd_neg ^ dsr_neg;
            rneg_p0 <= dvd_neg;
            dz_p0   <= (divisor == '0);
            ovf_p0  <= ovf_case;
            state   <= (divisor == '0) ? FINISH : RUN;
          end
        end
        // Iterate: shift, trial-subtract, keep or restore
        RUN: begin
          if (!trial[WIDTH]) begin
            rem_p0 <= trial;
            quo_p0 <= {quo_p0[WIDTH-2:0], 1'b1};
          end else begin
            rem_p0 <= rem_sh;
            quo_p0 <= {quo_p0[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        // Result: restore signs and publish with a one-cycle done
        FINISH: begin
          if (dz_p0) begin
            quotient  <= '1;
            remainder <= dvd_p0;
          end else begin
            quotient  <= apply_sign(quo_p0, qneg_p0);
            remainder <= apply_sign(rem_p0[WIDTH-1:0], rneg_p0);
          end
          div_by_zero <= dz_p0;
          overflow    <= ovf_p0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8 and WIDTH=16: an arithmetic reference model
// predicts every output on every cycle; directed cases pin literal results.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, sm8, busy8, done8, dz8, ov8;
  logic [7:0]  dvd8, dsr8, q8, r8;
  logic        start16, sm16, busy16, done16, dz16, ov16;
  logic [15:0] dvd16, dsr16, q16, r16;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .dividend(dvd8), .divisor(dsr8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .dividend(dvd16), .divisor(dsr16), .busy(busy16), .done(done16),
    .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference-model state per instance (0: WIDTH=8, 1: WIDTH=16)
  bit          m_busy [2];
  bit          m_done [2];
  logic [15:0] m_q    [2];
  logic [15:0] m_r    [2];
  bit          m_dz   [2];
  bit          m_ov   [2];
  logic [15:0] p_q    [2];
  logic [15:0] p_r    [2];
  bit          p_dz   [2];
  bit          p_ov   [2];
  int          m_cnt  [2];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Division by plain integer arithmetic on sign-interpreted operands
  function automatic void ref_div(input int w, input bit sm, input logic [15:0] a_in,
                                  input logic [15:0] b_in, output logic [15:0] q,
                                  output logic [15:0] r, output bit dz, output bit ov);
    longint mask, half, a, b, sa, sb;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a = longint'(a_in) & mask;
    b = longint'(b_in) & mask;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = 16'(mask);
      r  = 16'(a);
      dz = 1'b1;
    end else if (sm) begin
      sa = (a >= half) ? a - (mask + 1) : a;
      sb = (b >= half) ? b - (mask + 1) : b;
      if (sa == -half && sb == -1) begin
        q  = 16'(half);
        r  = '0;
        ov = 1'b1;
      end else begin
        q = 16'((sa / sb) & mask);
        r = 16'((sa % sb) & mask);
      end
    end else begin
      q = 16'(a / b);
      r = 16'(a % b);
    end
  endfunction

  task automatic model_step(input int i, input bit rs, input bit st, input bit sm,
                            input logic [15:0] a, input logic [15:0] b);
    if (rs) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_q[i] = '0; m_r[i] = '0;
      m_dz[i] = 1'b0; m_ov[i] = 1'b0; m_cnt[i] = 0;
    end else begin
      m_done[i] = 1'b0;
      if (m_busy[i]) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          m_q[i] = p_q[i]; m_r[i] = p_r[i]; m_dz[i] = p_dz[i]; m_ov[i] = p_ov[i];
        end
      end else if (st) begin
        ref_div(wid(i), sm, a, b, p_q[i], p_r[i], p_dz[i], p_ov[i]);
        m_busy[i] = 1'b1;
        m_cnt[i]  = p_dz[i] ? 1 : wid(i) + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst, start8, sm8, {8'h00, dvd8}, {8'h00, dsr8});
    model_step(1, rst, start16, sm16, dvd16, dsr16);
  end

  task automatic cmp(input int i, input logic b, input logic d, input logic [15:0] q,
                     input logic [15:0] r, input logic z, input logic v);
    chk($sformatf("busy_w%0d", wid(i)), 32'(b), 32'(m_busy[i]));
    chk($sformatf("done_w%0d", wid(i)), 32'(d), 32'(m_done[i]));
    chk($sformatf("quotient_w%0d", wid(i)), 32'(q), 32'(m_q[i]));
    chk($sformatf("remainder_w%0d", wid(i)), 32'(r), 32'(m_r[i]));
    chk($sformatf("div_by_zero_w%0d", wid(i)), 32'(z), 32'(m_dz[i]));
    chk($sformatf("overflow_w%0d", wid(i)), 32'(v), 32'(m_ov[i]));
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp(0, busy8, done8, {8'h00, q8}, {8'h00, r8}, dz8, ov8);
      cmp(1, busy16, done16, q16, r16, dz16, ov16);
    end
  end

  function automatic logic get_done(input int i);
    return (i == 0) ? done8 : done16;
  endfunction

  task automatic drive(input int i, input logic st, input logic sm,
                       input logic [15:0] a, input logic [15:0] b);
    if (i == 0) begin
      start8 = st; sm8 = sm; dvd8 = a[7:0]; dsr8 = b[7:0];
    end else begin
      start16 = st; sm16 = sm; dvd16 = a; dsr16 = b;
    end
  endtask

  // One-cycle start pulse; returns at the negedge after the accept edge with
  // operands scrambled to show they need not be held.
  task automatic go(input int i, input logic sm, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    drive(i, 1'b1, sm, a, b);
    @(negedge clk);
    drive(i, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (get_done(i) === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout_w%0d: got no done expected done within 40 cycles", wid(i));
  endtask

  task automatic expect_res(input string name, input int i, input int n, input int lat,
                            input logic [15:0] eq, input logic [15:0] er,
                            input logic edz, input logic eov);
    chk({name, "_latency"}, 32'(n), 32'(lat));
    if (i == 0) begin
      chk({name, "_q"}, 32'(q8), 32'(eq));
      chk({name, "_r"}, 32'(r8), 32'(er));
      chk({name, "_dz"}, 32'(dz8), 32'(edz));
      chk({name, "_ov"}, 32'(ov8), 32'(eov));
    end else begin
      chk({name, "_q"}, 32'(q16), 32'(eq));
      chk({name, "_r"}, 32'(r16), 32'(er));
      chk({name, "_dz"}, 32'(dz16), 32'(edz));
      chk({name, "_ov"}, 32'(ov16), 32'(eov));
    end
  endtask

  function automatic logic [15:0] pick(input int w);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'd1;
      2:       return mask;
      3:       return 16'(32'd1 << (w - 1));
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] tq, tr;
    bit tdz, tov;
    int n, i;
    logic sm;
    logic [15:0] a, b;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_q", 32'(q8), 32'd0);
    chk("rst_r", 32'(r8), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    rst = 1'b0;

    // Literal anchors for the reference model itself
    ref_div(8, 1'b0, 16'd100, 16'd7, tq, tr, tdz, tov);
    chk("model_u100_7_q", 32'(tq), 32'd14);
    chk("model_u100_7_r", 32'(tr), 32'd2);
    ref_div(8, 1'b1, 16'h00F9, 16'h0002, tq, tr, tdz, tov);
    chk("model_sm7_2_q", 32'(tq), 32'h0FD);
    chk("model_sm7_2_r", 32'(tr), 32'h0FF);
    ref_div(8, 1'b1, 16'h0080, 16'h00FF, tq, tr, tdz, tov);
    chk("model_ovf_q", 32'(tq), 32'h080);
    chk("model_ovf_flag", 32'(tov), 32'd1);
    ref_div(16, 1'b0, 16'hFFFF, 16'h00FF, tq, tr, tdz, tov);
    chk("model_w16_q", 32'(tq), 32'd257);

    go(0, 1'b0, 16'd100, 16'd7);
    wait_done(0, n);
    expect_res("u100_7", 0, n, 9, 16'd14, 16'd2, 1'b0, 1'b0);

    go(0, 1'b1, 16'h00F9, 16'h0002);
    wait_done(0, n);
    expect_res("s_m7_2", 0, n, 9, 16'h00FD, 16'h00FF, 1'b0, 1'b0);

    go(0, 1'b1, 16'h0007, 16'h00FE);
    wait_done(0, n);
    expect_res("s_7_m2", 0, n, 9, 16'h00FD, 16'h0001, 1'b0, 1'b0);

    go(0, 1'b0, 16'h0055, 16'h0000);
    wait_done(0, n);
    expect_res("dz", 0, n, 1, 16'h00FF, 16'h0055, 1'b1, 1'b0);

    go(0, 1'b0, 16'd100, 16'd7);
    wait_done(0, n);
    expect_res("dz_clear", 0, n, 9, 16'd14, 16'd2, 1'b0, 1'b0);

    go(0, 1'b1, 16'h0080, 16'h00FF);
    wait_done(0, n);
    expect_res("s_ovf", 0, n, 9, 16'h0080, 16'h0000, 1'b0, 1'b1);

    // Reset at RUN iteration 4 of a fresh operation
    go(0, 1'b0, 16'd200, 16'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_q", 32'(q8), 32'd0);
    chk("midrst_r", 32'(r8), 32'd0);
    chk("midrst_ov", 32'(ov8), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done8), 32'd0);
    end

    // Start pulsed while busy must not disturb the running divide
    go(0, 1'b0, 16'd100, 16'd7);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h0003);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    wait_done(0, n);
    expect_res("busy_start", 0, n, 6, 16'd14, 16'd2, 1'b0, 1'b0);

    // Start during the done cycle is accepted
    go(0, 1'b0, 16'd100, 16'd7);
    wait_done(0, n);
    drive(0, 1'b1, 1'b1, 16'h00F9, 16'h0002);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    wait_done(0, n);
    expect_res("done_cycle_start", 0, n, 9, 16'h00FD, 16'h00FF, 1'b0, 1'b0);

    go(1, 1'b0, 16'hFFFF, 16'h00FF);
    wait_done(1, n);
    expect_res("w16_u", 1, n, 17, 16'd257, 16'd0, 1'b0, 1'b0);

    // Randomised sweep on both widths
    for (int k = 0; k < 160; k++) begin
      i  = k % 2;
      sm = 1'($urandom);
      a  = pick(wid(i));
      b  = pick(wid(i));
      ref_div(wid(i), sm, a, b, tq, tr, tdz, tov);
      go(i, sm, a, b);
      wait_done(i, n);
      expect_res($sformatf("rand%0d", k), i, n, tdz ? 1 : wid(i) + 1, tq, tr, tdz, tov);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
